// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction fetch path.
package mips_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam logic [INSTR_W-1:0] NOP = 32'h0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries; flush dominates push and pop.
import mips_pkg::*;

module fetch_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [2*INSTR_W-1:0]       push_data,
   input  logic                       pop,
   input  logic                       flush,
   output logic [2*INSTR_W-1:0]       head,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [2*INSTR_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]        rd_ptr_q, wr_ptr_q;
   logic [AW:0]          count_q;
   logic                 do_push, do_pop;

   // A push into a full FIFO is legal only when the head leaves in the same cycle.
   assign do_pop  = pop && (count_q != '0);
   assign do_push = push && ((count_q != FULL_CNT) || do_pop);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/mips_fetch_unit.sv
// Fetch stage: one-outstanding imem request, instruction FIFO, redirect flush.
// Optional FETCH_STATS_EN adds FetchCount/FlushCount counters.
import mips_pkg::*;

module mips_fetch_unit #(
   parameter int unsigned         DEPTH    = 4,
   parameter logic [INSTR_W-1:0]  RESET_PC = 32'h0000_0000
) (
   input  logic               Clk,
   input  logic               Res,
   output logic               IMemReq,
   output logic [INSTR_W-1:0] IMemAddr,
   input  logic               IMemAck,
   input  logic [INSTR_W-1:0] IMemData,
   output logic               InstrValid,
   output logic [INSTR_W-1:0] Instr,
   output logic [INSTR_W-1:0] InstrPC,
   input  logic               InstrReady,
   input  logic               Redirect,
   input  logic [INSTR_W-1:0] RedirectPC
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]        FetchCount,
   output logic [31:0]        FlushCount
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   fetch_state_e         state_q, state_d;
   logic [INSTR_W-1:0]   pc_q, pc_d;
   logic [INSTR_W-1:0]   addr_q, addr_d;
   logic [INSTR_W-1:0]   target;
   logic                 xfer, push, pop;
   logic [AW:0]          count, count_after;
   logic [2*INSTR_W-1:0] head;

   assign IMemReq     = (state_q != IDLE);
   assign IMemAddr    = addr_q;
   assign xfer        = IMemReq && IMemAck;
   assign target      = {RedirectPC[INSTR_W-1:2], 2'b00};
   assign pop         = InstrValid && InstrReady;
   assign count_after = count + 1'b1 - {{AW{1'b0}}, pop};

   // pc_q is the next fetch address; it differs from addr_q only in DROP,
   // where addr_q holds the abandoned request and pc_q the redirect target.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      push    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (Redirect) begin
               pc_d    = target;
               addr_d  = target;
               state_d = REQ;
            end else if (count < FULL_CNT) begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (xfer && Redirect) begin
               pc_d   = target;
               addr_d = target;
            end else if (xfer) begin
               push    = 1'b1;
               pc_d    = addr_q + 32'd4;
               addr_d  = addr_q + 32'd4;
               state_d = (count_after < FULL_CNT) ? REQ : IDLE;
            end else if (Redirect) begin
               pc_d    = target;
               state_d = DROP;
            end
         end
         DROP: begin
            if (Redirect) begin
               pc_d = target;
            end
            if (xfer) begin
               addr_d  = Redirect ? target : pc_q;
               state_d = REQ;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Res) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (Clk),
      .rst       (Res),
      .push      (push),
      .push_data ({addr_q, IMemData}),
      .pop       (pop),
      .flush     (Redirect),
      .head      (head),
      .count     (count)
   );

   assign InstrValid = (count != '0);
   assign Instr      = InstrValid ? head[INSTR_W-1:0] : NOP;
   assign InstrPC    = InstrValid ? head[2*INSTR_W-1:INSTR_W] : '0;

`ifdef FETCH_STATS_EN
   logic [31:0] fetch_cnt_q, flush_cnt_q;

   always_ff @(posedge Clk) begin
      if (Res) begin
         fetch_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (push) fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (Redirect) flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign FetchCount = fetch_cnt_q;
   assign FlushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed self-checking bench for mips_fetch_unit (DEPTH=4, RESET_PC=0).
module tb_mips_fetch_unit;

   logic        Clk = 1'b0;
   logic        Res;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic        IMemAck;
   logic [31:0] IMemData;
   logic        InstrValid;
   logic [31:0] Instr;
   logic [31:0] InstrPC;
   logic        InstrReady;
   logic        Redirect;
   logic [31:0] RedirectPC;
`ifdef FETCH_STATS_EN
   logic [31:0] FetchCount;
   logic [31:0] FlushCount;
`endif

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #5 Clk = ~Clk;

   mips_fetch_unit #(
      .DEPTH    (4),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .Clk        (Clk),
      .Res        (Res),
      .IMemReq    (IMemReq),
      .IMemAddr   (IMemAddr),
      .IMemAck    (IMemAck),
      .IMemData   (IMemData),
      .InstrValid (InstrValid),
      .Instr      (Instr),
      .InstrPC    (InstrPC),
      .InstrReady (InstrReady),
      .Redirect   (Redirect),
      .RedirectPC (RedirectPC)
`ifdef FETCH_STATS_EN
      ,
      .FetchCount (FetchCount),
      .FlushCount (FlushCount)
`endif
   );

   // Memory contents: each word is its own address tagged in the top half.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   assign IMemData = mem_word(IMemAddr);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic hold_reset();
      Res = 1'b1;
      step();
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      Res        = 1'b1;
      IMemAck    = 1'b1;
      InstrReady = 1'b1;
      Redirect   = 1'b0;
      RedirectPC = 32'h0;

      // Streaming with zero-wait memory
      hold_reset();
      check("rst_req",   {31'b0, IMemReq}, 32'd0);
      check("rst_addr",  IMemAddr, 32'h0);
      check("rst_valid", {31'b0, InstrValid}, 32'd0);
      check("rst_instr", Instr, 32'h0);
      check("rst_pc",    InstrPC, 32'h0);
      Res = 1'b0;
      step();
      check("first_req",  {31'b0, IMemReq}, 32'd1);
      check("first_addr", IMemAddr, 32'h0);
      step();
      for (int i = 0; i < 5; i++) begin
         check("stream_valid", {31'b0, InstrValid}, 32'd1);
         check("stream_pc",    InstrPC, 32'(i * 4));
         check("stream_instr", Instr, mem_word(32'(i * 4)));
         step();
      end

      // Backpressure fills the FIFO and stops fetch
      InstrReady = 1'b0;
      hold_reset();
      Res = 1'b0;
      repeat (5) step();
      check("full_req",   {31'b0, IMemReq}, 32'd0);
      check("full_valid", {31'b0, InstrValid}, 32'd1);
      check("full_pc",    InstrPC, 32'h0);
      check("full_addr",  IMemAddr, 32'h10);
      step();
      step();
      check("full_req_hold", {31'b0, IMemReq}, 32'd0);
      check("full_pc_hold",  InstrPC, 32'h0);
      InstrReady = 1'b1;
      for (int k = 0; k < 8 && !IMemReq; k++) step();
      check("resume_req",  {31'b0, IMemReq}, 32'd1);
      check("resume_addr", IMemAddr, 32'h10);
      check("resume_pc",   InstrPC, 32'h8);

      // Slow memory, redirect while waiting
      IMemAck = 1'b0;
      hold_reset();
      Res = 1'b0;
      step();
      Redirect   = 1'b1;
      RedirectPC = 32'h100;
      step();
      Redirect = 1'b0;
      check("drop_req",  {31'b0, IMemReq}, 32'd1);
      check("drop_addr", IMemAddr, 32'h0);
      step();
      check("drop_addr_hold", IMemAddr, 32'h0);
      IMemAck = 1'b1;
      step();
      check("redir_req",     {31'b0, IMemReq}, 32'd1);
      check("redir_addr",    IMemAddr, 32'h100);
      check("no_stale",      {31'b0, InstrValid}, 32'd0);
      step();
      check("redir_valid", {31'b0, InstrValid}, 32'd1);
      check("redir_pc",    InstrPC, 32'h100);
      check("redir_instr", Instr, mem_word(32'h100));

      // Redirect coincident with ack and pop; low address bits ignored
      Redirect   = 1'b1;
      RedirectPC = 32'h203;
      step();
      Redirect = 1'b0;
      check("flush_valid", {31'b0, InstrValid}, 32'd0);
      check("flush_addr",  IMemAddr, 32'h200);
      step();
      check("flush_pc", InstrPC, 32'h200);

      // PC wrap
      Redirect   = 1'b1;
      RedirectPC = 32'hFFFF_FFFC;
      step();
      Redirect = 1'b0;
      check("wrap_top", IMemAddr, 32'hFFFF_FFFC);
      step();
      check("wrap_addr", IMemAddr, 32'h0);
      check("wrap_pc",   InstrPC, 32'hFFFF_FFFC);
      step();
      check("wrap_pc0",  InstrPC, 32'h0);

`ifdef FETCH_STATS_EN
      IMemAck = 1'b0;
      hold_reset();
      check("stat_rst_fetch", FetchCount, 32'd0);
      check("stat_rst_flush", FlushCount, 32'd0);
      Res = 1'b0;
      step();
      IMemAck = 1'b1;
      repeat (10) step();
      IMemAck    = 1'b0;
      Redirect   = 1'b1;
      RedirectPC = 32'h40;
      step();
      step();
      Redirect = 1'b0;
      check("stat_fetch", FetchCount, 32'd10);
      check("stat_flush", FlushCount, 32'd2);
      Res = 1'b1;
      step();
      check("stat_res_fetch", FetchCount, 32'd0);
      check("stat_res_flush", FlushCount, 32'd0);
      check("stat_res_req",   {31'b0, IMemReq}, 32'd0);
      Res = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
